// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin scheduler that shares one UART transmitter among N_REQ byte
//   sources. A winner may send up to MAX_BURST consecutive bytes before the
//   grant is re-arbitrated. A start request that the transmitter does not
//   accept within TIMEOUT cycles is dropped and the sticky err flag is set.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high reset
//   req       in   [N_REQ]     per-requester byte-pending flag
//   req_data  in   [8*N_REQ]   byte of requester i on bits [8i+7:8i]
//   ack       out  [N_REQ]     one-hot, one-cycle pulse when a byte is latched
//   tx_start  out              start request to the transmitter
//   tx_data   out  [8]         byte presented to the transmitter
//   tx_busy   in               transmitter busy
//   owner     out  [clog2]     index of the currently granted requester
//   active    out              high whenever the FSM is not idle
//   err       out              sticky start-timeout flag
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no grant; arbitrate among pending requesters
// LAUNCH    | tx_start high, waiting for tx_busy (timeout counter runs)
// WAIT_DONE | frame in flight; on busy falling continue burst or release
module uart_tx_scheduler #(
  parameter  int N_REQ     = 4,
  parameter  int MAX_BURST = 16,
  parameter  int TIMEOUT   = 4,
  localparam int OW        = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic [OW-1:0]      owner,
  output logic               active,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_ack;
  logic [7:0]       r_tx_data;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_last;
  logic [7:0]       r_burst;
  logic [3:0]       r_tmo;
  logic             r_err;

  logic [7:0]       w_bytes [N_REQ];
  logic [OW-1:0]    w_idx;
  logic [OW-1:0]    w_winner;
  logic             w_found;
  logic             w_continue;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  // Rotating priority search: offset 1 is the requester after the last
  // grant, offset N_REQ wraps back to the last grant itself.
  always_comb begin
    w_idx    = '0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = OW'((int'(r_last) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_continue = req[r_owner] && (r_burst < 8'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ack     <= '0;
      r_tx_data <= '0;
      r_owner   <= '0;
      r_last    <= OW'(N_REQ - 1);
      r_burst   <= '0;
      r_tmo     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_tx_data <= w_bytes[w_winner];
            r_owner   <= w_winner;
            r_ack     <= N_REQ'(1) << w_winner;
            r_burst   <= 8'd1;
            r_tmo     <= '0;
            r_state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_tmo <= r_tmo + 4'd1;
          if (tx_busy) begin
            r_state <= S_WAIT;
          end else if (r_tmo + 4'd1 == 4'(TIMEOUT)) begin
            // Byte was already acked, so it is dropped rather than retried.
            r_err   <= 1'b1;
            r_last  <= r_owner;
            r_burst <= '0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!tx_busy) begin
            if (w_continue) begin
              r_tx_data <= w_bytes[r_owner];
              r_ack     <= N_REQ'(1) << r_owner;
              r_burst   <= r_burst + 8'd1;
              r_tmo     <= '0;
              r_state   <= S_LAUNCH;
            end else begin
              r_last  <= r_owner;
              r_burst <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack      = r_ack;
  assign tx_data  = r_tx_data;
  assign owner    = r_owner;
  assign err      = r_err;
  assign tx_start = (r_state == S_LAUNCH);
  assign active   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 4;

  logic           clk      = 1'b0;
  logic           reset    = 1'b1;
  logic [N-1:0]   req      = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy  = 1'b0;
  logic [1:0]     owner;
  logic           active;
  logic           err;

  uart_tx_scheduler #(.N_REQ(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .owner(owner), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // environment: requester byte queues, transmitter model, monitors
  typedef logic [7:0] bq_t [$];
  bq_t        rq [N];
  int         ack_log [$];
  int         cap_owner [$];
  logic [7:0] cap_byte [$];
  logic       line_log [$];
  int         onehot_bad = 0;
  int         stab_bad   = 0;
  logic       tx_en      = 1'b1;
  int         bp         = 1;
  int         dly_min    = 0;
  int         dly_max    = 0;
  logic       log_line   = 1'b0;
  logic       line_o     = 1'b1;
  logic       waiting    = 1'b0;
  int         acc_wait   = 0;
  int         cur_delay  = 0;
  int         tx_cnt     = 0;
  int         bidx       = 0;
  logic [7:0] cap_data   = '0;

  always @(negedge clk) begin
    if (reset) begin
      tx_busy = 1'b0; line_o = 1'b1; waiting = 1'b0; tx_cnt = 0;
    end else if (tx_busy) begin
      if (tx_data !== cap_data) stab_bad++;
      tx_cnt++;
      if (tx_cnt >= 10*bp) begin
        tx_busy = 1'b0; line_o = 1'b1;
      end else begin
        bidx = tx_cnt / bp;
        line_o = (bidx == 0) ? 1'b0 : (bidx == 9) ? 1'b1 : cap_data[3'(8 - bidx)];
      end
    end else if (tx_en && tx_start) begin
      if (!waiting) begin
        waiting = 1'b1; acc_wait = 0; cur_delay = $urandom_range(dly_max, dly_min);
      end
      if (acc_wait < cur_delay) acc_wait++;
      else begin
        waiting = 1'b0; tx_busy = 1'b1; tx_cnt = 0; cap_data = tx_data; line_o = 1'b0;
        cap_owner.push_back(int'(owner)); cap_byte.push_back(tx_data);
      end
    end
    if (log_line) line_log.push_back(line_o);
    if (ack != '0) begin
      if ($countones(ack) != 1) onehot_bad++;
      for (int i = 0; i < N; i++)
        if (ack[i]) begin
          ack_log.push_back(i);
          if (rq[i].size() > 0) void'(rq[i].pop_front());
        end
    end
    for (int i = 0; i < N; i++) begin
      req[i] = (rq[i].size() != 0);
      req_data[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
    end
  end

  // Reference: all requests present up front, each requester keeps req high
  // until its queue is empty -> round robin with burst cap.
  function automatic void model_grants(input int len [N], output int exp_q [$]);
    int rem [N];
    int last;
    int left;
    last = N - 1; left = 0;
    for (int i = 0; i < N; i++) begin rem[i] = len[i]; left += len[i]; end
    exp_q.delete();
    while (left > 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        int take;
        c = (last + k) % N;
        if (rem[c] > 0) begin
          take = (rem[c] < MB) ? rem[c] : MB;
          repeat (take) exp_q.push_back(c);
          rem[c] -= take; left -= take; last = c;
          break;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    step();
    reset = 1'b0;
    ack_log.delete(); cap_owner.delete(); cap_byte.delete();
    onehot_bad = 0; stab_bad = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int pend;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      pend = 0;
      for (int i = 0; i < N; i++) pend += rq[i].size();
      if (pend == 0 && !active && !tx_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (ack !== '0 || tx_start !== 1'b0 || tx_data !== 8'h00 || owner !== 2'd0 ||
        active !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ack=%b start=%b data=%h owner=%0d active=%b err=%b, want all 0",
               ack, tx_start, tx_data, owner, active, err);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int n;
    bit seen;
    bit ok;
    do_reset();
    dly_min = 2; dly_max = 2; bp = 1;
    rq[2].push_back(8'hA5);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ack != '0) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL single_ack_seen: no ack within 20 cycles"); end
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", ack); end
    checks++;
    if (tx_data !== 8'hA5 || owner !== 2'd2 || tx_start !== 1'b1 || active !== 1'b1) begin
      errors++;
      $display("FAIL single_load: data=%h owner=%0d start=%b active=%b want a5 2 1 1",
               tx_data, owner, tx_start, active);
    end
    n = 1;
    step();
    checks++;
    if (ack !== '0) begin errors++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
    while (tx_start === 1'b1 && n < 20) begin n++; step(); end
    checks++;
    if (n != 3) begin errors++; $display("FAIL single_start_len: got %0d want 3", n); end
    checks++;
    if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_start_drop: busy=%b when start fell, want 1", tx_busy); end
    wait_done(200, ok);
    checks++;
    if (!ok || cap_byte.size() != 1 || cap_byte[0] !== 8'hA5 || ack_log.size() != 1) begin
      errors++;
      $display("FAIL single_capture: done=%b bytes=%0d acks=%0d want 1 byte a5", ok, cap_byte.size(), ack_log.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    dly_min = 0; dly_max = 2; bp = 1;
    for (int i = 0; i < N; i++) rq[i].push_back(8'(8'h10 + i));
    wait_done(500, ok);
    checks++;
    if (!ok || ack_log.size() != 4) begin
      errors++; $display("FAIL rr_count: done=%b acks=%0d want 4", ok, ack_log.size());
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (i >= ack_log.size() || ack_log[i] != i || cap_byte[i] !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL rr_order[%0d]: got owner %0d byte %h want %0d %h",
                           i, ack_log[i], cap_byte[i], i, 8'(8'h10 + i));
      end
    end
    checks++;
    if (onehot_bad != 0) begin errors++; $display("FAIL rr_onehot: %0d bad acks want 0", onehot_bad); end
  endtask

  task automatic test_burst();
    int len [N];
    int exp_q [$];
    bit ok;
    int k1;
    do_reset();
    dly_min = 0; dly_max = 1; bp = 1;
    for (int k = 0; k < 20; k++) rq[1].push_back(8'(8'h80 + k));
    rq[3].push_back(8'hF3);
    len = '{0, 20, 0, 1};
    model_grants(len, exp_q);
    wait_done(3000, ok);
    checks++;
    if (!ok || ack_log.size() != exp_q.size()) begin
      errors++; $display("FAIL burst_count: done=%b acks=%0d want %0d", ok, ack_log.size(), exp_q.size());
    end
    k1 = 0;
    for (int j = 0; j < exp_q.size(); j++) begin
      logic [7:0] eb;
      eb = (exp_q[j] == 3) ? 8'hF3 : 8'(8'h80 + k1);
      if (exp_q[j] == 1) k1++;
      checks++;
      if (j >= ack_log.size() || ack_log[j] != exp_q[j] || cap_owner[j] != exp_q[j] || cap_byte[j] !== eb) begin
        errors++; $display("FAIL burst_seq[%0d]: got owner %0d byte %h want %0d %h",
                           j, ack_log[j], cap_byte[j], exp_q[j], eb);
      end
    end
    checks++;
    if (ack_log.size() < 17 || ack_log[15] != 1 || ack_log[16] != 3) begin
      errors++; $display("FAIL burst_cap: owner at byte 16 is %0d want 3", ack_log[16]);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    do_reset();
    tx_en = 1'b0;
    rq[1].push_back(8'h11);
    rq[2].push_back(8'h22);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ack != '0) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || ack !== 4'b0010) begin errors++; $display("FAIL to_first_grant: got %b want 0010", ack); end
    n = 0;
    while (tx_start === 1'b1 && n < 20) begin n++; step(); end
    checks++;
    if (n != TO) begin errors++; $display("FAIL to_start_len: got %0d want %0d", n, TO); end
    checks++;
    if (err !== 1'b1 || active !== 1'b0) begin
      errors++; $display("FAIL to_err_idle: err=%b active=%b want 1 0", err, active);
    end
    step();
    checks++;
    if (ack !== 4'b0100 || owner !== 2'd2) begin
      errors++; $display("FAIL to_next_grant: ack=%b owner=%0d want 0100 2", ack, owner);
    end
    repeat (8) step();
    checks++;
    if (err !== 1'b1 || active !== 1'b0 || ack_log.size() != 2) begin
      errors++; $display("FAIL to_sticky: err=%b active=%b acks=%0d want 1 0 2", err, active, ack_log.size());
    end
    tx_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    dly_min = 0; dly_max = 0; bp = 3;
    rq[0] = '{8'h01, 8'h02, 8'h03};
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (tx_busy && active && !tx_start) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rmid_wait: never reached transfer in flight"); end
    reset = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    step();
    checks++;
    if (ack !== '0 || tx_start !== 1'b0 || tx_data !== 8'h00 || owner !== 2'd0 ||
        active !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs: ack=%b start=%b data=%h owner=%0d active=%b err=%b want all 0",
               ack, tx_start, tx_data, owner, active, err);
    end
    reset = 1'b0;
    rq[3].push_back(8'h33);
    rq[0].push_back(8'h44);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ack != '0) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || ack !== 4'b0001 || tx_data !== 8'h44) begin
      errors++; $display("FAIL rmid_first_grant: ack=%b data=%h want 0001 44", ack, tx_data);
    end
    begin
      bit ok;
      wait_done(500, ok);
    end
  endtask

  task automatic test_serial();
    bit ok;
    logic [7:0] frames [$];
    int bad;
    int i;
    do_reset();
    dly_min = 0; dly_max = 1; bp = 2;
    line_log.delete();
    log_line = 1'b1;
    rq[0] = '{8'h3C, 8'hC3};
    wait_done(500, ok);
    repeat (3) step();
    log_line = 1'b0;
    bad = 0; i = 0;
    while (i < line_log.size()) begin
      if (line_log[i] == 1'b0) begin
        logic [7:0] b;
        if (i + 10*bp > line_log.size()) begin bad++; break; end
        for (int j = 0; j < 8; j++) b[7-j] = line_log[i + (1+j)*bp];
        if (line_log[i + 9*bp] != 1'b1) bad++;
        frames.push_back(b);
        i += 10*bp;
      end else i++;
    end
    checks++;
    if (!ok || bad != 0 || frames.size() != 2) begin
      errors++; $display("FAIL serial_frames: done=%b framing_errs=%0d frames=%0d want 2 clean", ok, bad, frames.size());
    end
    checks++;
    if (frames.size() < 2 || frames[0] !== 8'h3C || frames[1] !== 8'hC3) begin
      errors++; $display("FAIL serial_bytes: got %h %h want 3c c3", frames[0], frames[1]);
    end
  endtask

  task automatic test_random();
    int len [N];
    int exp_q [$];
    bq_t dat [N];
    int used [N];
    bit ok;
    int c;
    logic [7:0] eb;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      bp = $urandom_range(2, 1); dly_min = 0; dly_max = 2;
      for (int i = 0; i < N; i++) begin
        len[i] = $urandom_range(20, 0);
        dat[i].delete();
        for (int k = 0; k < len[i]; k++) dat[i].push_back(8'($urandom));
        rq[i] = dat[i];
        used[i] = 0;
      end
      model_grants(len, exp_q);
      wait_done(6000, ok);
      checks++;
      if (!ok || ack_log.size() != exp_q.size() || cap_byte.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_count it=%0d: done=%b acks=%0d bytes=%0d want %0d",
                           it, ok, ack_log.size(), cap_byte.size(), exp_q.size());
      end
      for (int j = 0; j < exp_q.size(); j++) begin
        c = exp_q[j];
        eb = dat[c][used[c]];
        used[c]++;
        checks++;
        if (j >= ack_log.size() || j >= cap_byte.size() || ack_log[j] != c ||
            cap_owner[j] != c || cap_byte[j] !== eb) begin
          errors++; $display("FAIL rand_seq it=%0d [%0d]: got owner %0d byte %h want %0d %h",
                             it, j, ack_log[j], cap_byte[j], c, eb);
        end
      end
      checks++;
      if (onehot_bad != 0 || stab_bad != 0 || err !== 1'b0) begin
        errors++; $display("FAIL rand_health it=%0d: onehot_bad=%0d data_changes=%0d err=%b want 0 0 0",
                           it, onehot_bad, stab_bad, err);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_serial();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
